// File: rtl/jump_physics.sv
// Vertical-motion controller for the player sprite: integrates gravity into a
// signed per-frame Y velocity with hold-to-extend jumps, air jumps and terminal fall.
module jump_physics #(
    parameter int         VEL_W         = 8,
    parameter logic [7:0] JUMP_KEY      = 8'h1A,
    parameter int         LAUNCH_VEL    = 10,
    parameter int         GRAVITY       = 1,
    parameter int         HOLD_FRAMES   = 8,
    parameter int         MAX_FALL      = 6,
    parameter int         MAX_AIR_JUMPS = 1,
    localparam int        AJ_W          = (MAX_AIR_JUMPS > 0) ? $clog2(MAX_AIR_JUMPS + 1) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_en,
    input  logic [7:0]              keycode,
    input  logic [7:0]              keycode2,
    input  logic                    grounded,
    input  logic                    head_bump,
    output logic signed [VEL_W-1:0] Y_Velocity,
    output logic [1:0]              jump_state,
    output logic [AJ_W-1:0]         air_jumps_used
);

    localparam int HC_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [HC_W-1:0]         HOLD_MAX = HC_W'(HOLD_FRAMES);
    localparam logic [AJ_W-1:0]         AJ_MAX   = AJ_W'(MAX_AIR_JUMPS);
    localparam logic signed [VEL_W:0]   GRAV_X   = (VEL_W + 1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   FALL_X   = (VEL_W + 1)'(MAX_FALL);
    localparam logic signed [VEL_W:0]   LNEG_X   = -((VEL_W + 1)'(LAUNCH_VEL));
    localparam logic signed [VEL_W-1:0] LAUNCH_V = LNEG_X[VEL_W-1:0];
    localparam logic signed [VEL_W-1:0] VEL_ZERO = {VEL_W{1'b0}};

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic [HC_W-1:0]         hold_q, hold_d;
    logic [AJ_W-1:0]         aj_q, aj_d;
    logic                    key_prev_q, key_prev_d;

    logic                    key_held;
    logic                    key_press;
    logic                    air_avail;
    logic signed [VEL_W:0]   vel_sum;
    logic signed [VEL_W-1:0] vel_grav;

    // The extra bit keeps vel+GRAVITY from wrapping before the clamp sees it.
    function automatic logic signed [VEL_W-1:0] clamp_vel(input logic signed [VEL_W:0] v);
        logic signed [VEL_W-1:0] r;
        if (v > FALL_X) begin
            r = FALL_X[VEL_W-1:0];
        end else if (v < LNEG_X) begin
            r = LNEG_X[VEL_W-1:0];
        end else begin
            r = v[VEL_W-1:0];
        end
        return r;
    endfunction

    assign key_held  = (keycode == JUMP_KEY) || (keycode2 == JUMP_KEY);
    assign key_press = key_held && !key_prev_q;
    assign air_avail = (aj_q < AJ_MAX);
    assign vel_sum   = $signed({vel_q[VEL_W-1], vel_q}) + GRAV_X;
    assign vel_grav  = clamp_vel(vel_sum);

    // Next-state evaluation for one frame; everything holds while frame_en is low.
    always_comb begin
        state_d    = state_q;
        vel_d      = vel_q;
        hold_d     = hold_q;
        aj_d       = aj_q;
        key_prev_d = key_prev_q;
        if (frame_en) begin
            key_prev_d = key_held;
            case (state_q)
                ST_GROUND: begin
                    if (key_press) begin
                        state_d = ST_RISE;
                        vel_d   = LAUNCH_V;
                        hold_d  = {HC_W{1'b0}};
                    end else if (!grounded) begin
                        state_d = ST_FALL;
                        vel_d   = vel_grav;
                    end else begin
                        state_d = ST_GROUND;
                        vel_d   = VEL_ZERO;
                    end
                end
                ST_RISE: begin
                    if (head_bump) begin
                        state_d = ST_FALL;
                        vel_d   = VEL_ZERO;
                        hold_d  = HOLD_MAX;
                    end else begin
                        if (key_press && air_avail) begin
                            vel_d  = LAUNCH_V;
                            hold_d = {HC_W{1'b0}};
                            aj_d   = aj_q + AJ_W'(1);
                        end else if (key_held && (hold_q < HOLD_MAX)) begin
                            hold_d = hold_q + HC_W'(1);
                        end else begin
                            // Releasing the key forfeits the rest of the hold window.
                            vel_d  = vel_grav;
                            hold_d = HOLD_MAX;
                        end
                        if (!vel_d[VEL_W-1]) begin
                            state_d = ST_FALL;
                        end else begin
                            state_d = ST_RISE;
                        end
                    end
                end
                ST_FALL: begin
                    if (grounded) begin
                        state_d = ST_GROUND;
                        vel_d   = VEL_ZERO;
                        aj_d    = {AJ_W{1'b0}};
                        hold_d  = {HC_W{1'b0}};
                    end else if (key_press && air_avail) begin
                        state_d = ST_RISE;
                        vel_d   = LAUNCH_V;
                        hold_d  = {HC_W{1'b0}};
                        aj_d    = aj_q + AJ_W'(1);
                    end else begin
                        state_d = ST_FALL;
                        vel_d   = vel_grav;
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                    vel_d   = VEL_ZERO;
                    aj_d    = {AJ_W{1'b0}};
                    hold_d  = {HC_W{1'b0}};
                end
            endcase
        end else begin
            key_prev_d = key_prev_q;
        end
    end

    // State register; Reset wins over frame_en.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_GROUND;
            vel_q      <= VEL_ZERO;
            hold_q     <= {HC_W{1'b0}};
            aj_q       <= {AJ_W{1'b0}};
            key_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vel_q      <= vel_d;
            hold_q     <= hold_d;
            aj_q       <= aj_d;
            key_prev_q <= key_prev_d;
        end
    end

    assign Y_Velocity     = vel_q;
    assign jump_state     = state_q;
    assign air_jumps_used = aj_q;

endmodule

// File: tb/tb_jump_physics.sv
// Scoreboard bench for jump_physics: directed test-plan scenarios then random frames,
// each checked against a rule-level reference model.
module tb_jump_physics;

    localparam logic [7:0] KEY = 8'h1A;
    localparam logic [7:0] NK  = 8'h00;
    localparam int L   = 10;
    localparam int G   = 1;
    localparam int H   = 8;
    localparam int MF  = 6;
    localparam int MAJ = 1;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              frame_en = 1'b0;
    logic [7:0]        keycode = 8'h00;
    logic [7:0]        keycode2 = 8'h00;
    logic              grounded = 1'b1;
    logic              head_bump = 1'b0;
    logic signed [7:0] Y_Velocity;
    logic [1:0]        jump_state;
    logic [0:0]        air_jumps_used;

    jump_physics dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_en      (frame_en),
        .keycode       (keycode),
        .keycode2      (keycode2),
        .grounded      (grounded),
        .head_bump     (head_bump),
        .Y_Velocity    (Y_Velocity),
        .jump_state    (jump_state),
        .air_jumps_used(air_jumps_used)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int vel;
        int st;
        int aj;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: 0 ground, 1 rising, 2 falling
    int m_st = 0;
    int m_vel = 0;
    int m_aj = 0;
    int m_hold = 0;
    bit m_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int clampv(input int v);
        if (v > MF) return MF;
        if (v < -L) return -L;
        return v;
    endfunction

    task automatic model_frame(input logic [7:0] k1, input logic [7:0] k2, input bit g, input bit hb);
        bit held, press;
        held   = (k1 == KEY) || (k2 == KEY);
        press  = held && !m_prev;
        m_prev = held;
        if (m_st == 0) begin
            if (press) begin
                m_st = 1; m_vel = -L; m_hold = 0;
            end else if (!g) begin
                m_st = 2; m_vel = clampv(G);
            end
        end else if (m_st == 1) begin
            if (hb) begin
                m_st = 2; m_vel = 0; m_hold = H;
            end else begin
                if (press && m_aj < MAJ) begin
                    m_vel = -L; m_hold = 0; m_aj++;
                end else if (held && m_hold < H) begin
                    m_hold++;
                end else begin
                    m_vel = clampv(m_vel + G); m_hold = H;
                end
                if (m_vel >= 0) m_st = 2;
            end
        end else begin
            if (g) begin
                m_st = 0; m_vel = 0; m_aj = 0; m_hold = 0;
            end else if (press && m_aj < MAJ) begin
                m_st = 1; m_vel = -L; m_hold = 0; m_aj++;
            end else begin
                m_vel = clampv(m_vel + G);
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.vel = m_vel; e.st = m_st; e.aj = m_aj;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the frame edge.
    task automatic do_frame(input logic [7:0] k1, input logic [7:0] k2, input bit g, input bit hb);
        keycode = k1; keycode2 = k2; grounded = g; head_bump = hb;
        frame_en = 1'b1;
        model_frame(k1, k2, g, hb);
        q.push_back(snap());
        @(negedge Clk);
        frame_en = 1'b0;
    endtask

    task automatic do_reset(input bit fe);
        Reset = 1'b1; frame_en = fe;
        m_st = 0; m_vel = 0; m_aj = 0; m_hold = 0; m_prev = 1'b0;
        q.push_back(snap());
        @(negedge Clk);
        Reset = 1'b0; frame_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic fall_and_land();
        for (int i = 0; i < 40 && m_st != 2; i++) do_frame(NK, NK, 1'b0, 1'b0);
        do_frame(NK, NK, 1'b1, 1'b0);
    endtask

    // Monitor: each frame/reset edge presents a new expected result; other cycles must hold it.
    initial begin : monitor
        exp_t e, last;
        bit   upd;
        bit   armed = 1'b0;
        forever begin
            @(posedge Clk);
            upd = Reset || frame_en;
            @(negedge Clk);
            if (upd) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_empty: got output with no expected entry (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("vel", int'(Y_Velocity), e.vel);
                    chk("state", int'(jump_state), e.st);
                    chk("air_jumps", int'(air_jumps_used), e.aj);
                    last  = e;
                    armed = 1'b1;
                end
            end else if (armed) begin
                chk("frozen_vel", int'(Y_Velocity), last.vel);
                chk("frozen_state", int'(jump_state), last.st);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit         hk;
        logic [7:0] k1, k2;
        bit         g, hb;
        @(negedge Clk);
        do_reset(1'b0);
        chk("reset_vel", int'(Y_Velocity), 0);
        chk("reset_state", int'(jump_state), 0);

        // Tap
        do_frame(KEY, NK, 1'b1, 1'b0);
        chk("tap_launch", int'(Y_Velocity), -10);
        repeat (10) do_frame(NK, NK, 1'b0, 1'b0);
        chk("tap_apex_vel", int'(Y_Velocity), 0);
        chk("tap_apex_state", int'(jump_state), 2);
        repeat (9) do_frame(NK, NK, 1'b0, 1'b0);
        chk("tap_terminal", int'(Y_Velocity), 6);
        do_frame(NK, NK, 1'b1, 1'b0);
        chk("tap_land", int'(jump_state), 0);

        // Full hold
        do_frame(NK, KEY, 1'b1, 1'b0);
        repeat (8) do_frame(NK, KEY, 1'b0, 1'b0);
        chk("hold_9th", int'(Y_Velocity), -10);
        do_frame(NK, KEY, 1'b0, 1'b0);
        chk("hold_end", int'(Y_Velocity), -9);
        fall_and_land();

        // Double jump, third press ignored
        do_frame(KEY, NK, 1'b1, 1'b0);
        repeat (6) do_frame(NK, NK, 1'b0, 1'b0);
        chk("dj_pre", int'(Y_Velocity), -4);
        do_frame(KEY, NK, 1'b0, 1'b0);
        chk("dj_vel", int'(Y_Velocity), -10);
        chk("dj_used", int'(air_jumps_used), 1);
        do_frame(NK, NK, 1'b0, 1'b0);
        do_frame(KEY, NK, 1'b0, 1'b0);
        chk("dj_third", int'(Y_Velocity), -8);
        fall_and_land();
        chk("dj_cleared", int'(air_jumps_used), 0);

        // Head bump
        do_frame(KEY, NK, 1'b1, 1'b0);
        repeat (3) do_frame(NK, NK, 1'b0, 1'b0);
        do_frame(NK, NK, 1'b0, 1'b1);
        chk("bump_vel", int'(Y_Velocity), 0);
        chk("bump_state", int'(jump_state), 2);
        do_frame(NK, NK, 1'b0, 1'b0);
        chk("bump_next", int'(Y_Velocity), 1);
        fall_and_land();

        // Ledge, then land with the key held
        do_frame(NK, NK, 1'b0, 1'b0);
        chk("ledge_state", int'(jump_state), 2);
        chk("ledge_vel", int'(Y_Velocity), 1);
        do_frame(KEY, NK, 1'b1, 1'b0);
        chk("land_wins", int'(jump_state), 0);
        do_frame(KEY, NK, 1'b1, 1'b0);
        chk("no_rejump", int'(jump_state), 0);
        do_frame(NK, NK, 1'b1, 1'b0);
        do_frame(KEY, NK, 1'b1, 1'b0);
        chk("repress", int'(Y_Velocity), -10);

        // Gating and reset mid-RISE
        do_frame(KEY, NK, 1'b0, 1'b0);
        idle(5);
        chk("gate_vel", int'(Y_Velocity), -10);
        chk("gate_state", int'(jump_state), 1);
        do_reset(1'b0);
        chk("rst_state", int'(jump_state), 0);
        chk("rst_vel", int'(Y_Velocity), 0);
        do_frame(KEY, NK, 1'b1, 1'b0);
        do_frame(NK, NK, 1'b0, 1'b0);
        do_frame(KEY, NK, 1'b0, 1'b0);
        chk("pre_rst_aj", int'(air_jumps_used), 1);
        do_reset(1'b1);
        chk("rst_aj", int'(air_jumps_used), 0);
        chk("rst_dom_state", int'(jump_state), 0);

        // Random frames
        hk = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) hk = !hk;
            k1 = 8'($urandom_range(0, 255));
            k2 = 8'($urandom_range(0, 255));
            if (k1 == KEY) k1 = 8'h1B;
            if (k2 == KEY) k2 = 8'h1B;
            if (hk) begin
                if ($urandom_range(0, 1) == 0) k1 = KEY;
                else k2 = KEY;
            end
            if (m_st == 2) g = ($urandom_range(0, 5) == 0);
            else if (m_st == 0) g = ($urandom_range(0, 9) != 0);
            else g = ($urandom_range(0, 1) == 0);
            hb = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) do_reset(bit'($urandom_range(0, 1)));
            else do_frame(k1, k2, g, hb);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jump_physics.md
Name: jump_physics

Overview:
- Parametrised vertical-motion controller for the player sprite. Produces a signed per-frame Y velocity from the jump key, ground contact and ceiling contact.
- Generalises the fixed jump velocity table into a gravity-integrating model with:
  - variable jump height (hold-to-extend),
  - configurable air jumps (double jump),
  - terminal fall velocity,
  - head-bump cancel.
- Sits between keycode decode and the sprite position/collision logic; position logic adds Y_Velocity once per frame.

Parameters:
- VEL_W, 8: width of signed velocity output, two's complement.
- JUMP_KEY, 8'h1A: keycode that triggers or holds a jump.
- LAUNCH_VEL, 10: magnitude of take-off velocity; output is -LAUNCH_VEL. Must be < 2^(VEL_W-1).
- GRAVITY, 1: velocity increment per frame, positive is downward.
- HOLD_FRAMES, 8: maximum frames gravity is suppressed while the key stays held after launch.
- MAX_FALL, 6: terminal downward velocity; saturation limit.
- MAX_AIR_JUMPS, 1: extra jumps allowed while airborne. 0 disables them.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- frame_en, input, 1: one-Clk pulse per video frame; all state advances only on Clk edges with frame_en=1.
- keycode, input, 8: first keyboard keycode.
- keycode2, input, 8: second keyboard keycode.
- grounded, input, 1: sprite feet are on a solid tile, from collision logic.
- head_bump, input, 1: sprite head hit a solid tile this frame.
- Y_Velocity, output, VEL_W, signed: registered velocity for the current frame.
- jump_state, output, 2: 0=GROUND, 1=RISE, 2=FALL.
- air_jumps_used, output, $clog2(MAX_AIR_JUMPS+1) (min 1): air jumps consumed since last landing.

Behaviour:
- Reset (sync, dominates frame_en, valid mid-jump):
  - jump_state=GROUND, Y_Velocity=0, air_jumps_used=0, hold_cnt=0, key_prev=0.
  - All outputs are valid on the next Clk edge.
- Key decode:
  - held = (keycode==JUMP_KEY) | (keycode2==JUMP_KEY).
  - press = held & ~key_prev.
  - key_prev updates only on frame_en. A key held across landing does not re-jump; it must be released and pressed again.
- frame_en=0: all registers hold.
- Latency: inputs are sampled on a frame_en edge; the new Y_Velocity and jump_state are visible after that same edge. Latency is one Clk.
- GROUND (Y_Velocity=0):
  - press → RISE, vel=-LAUNCH_VEL, hold_cnt=0. press wins even if grounded=0.
  - else grounded=0 (walked off a ledge) → FALL, vel=+GRAVITY.
  - else stay.
- RISE, evaluated in priority order:
  1. head_bump → FALL, vel=0, hold_cnt=HOLD_FRAMES.
  2. press and air_jumps_used<MAX_AIR_JUMPS → stay RISE, vel=-LAUNCH_VEL, hold_cnt=0, air_jumps_used+1.
  3. held and hold_cnt<HOLD_FRAMES → vel unchanged, hold_cnt+1.
  4. else → vel+=GRAVITY, hold_cnt=HOLD_FRAMES. A release ends the hold for this jump; re-holding does not restore it.
  - If the resulting vel ≥ 0 → FALL.
  - grounded is ignored in RISE.
- FALL, evaluated in priority order:
  1. grounded → GROUND, vel=0, air_jumps_used=0, hold_cnt=0.
  2. press and air jumps remain → RISE, as in RISE step 2.
  3. else → vel=min(vel+GRAVITY, MAX_FALL).
  - head_bump is ignored in FALL.
- Arithmetic:
  - Additions use VEL_W+1 bits internally, then clamp to [-LAUNCH_VEL, MAX_FALL].
  - No wrap-around under any parameter set.
- Simultaneous grounded & press in FALL: landing wins. The press is consumed; key_prev=1, so no jump occurs until the key is re-pressed.
- Illegal jump_state encoding (3) → GROUND, vel=0 on the next frame_en.

Test Plan (default parameters; each step is one frame_en pulse):
- Tap:
  - Stimulus: press 1 frame in GROUND, then release.
  - Required: vel -10, -9, -8, …, -1, then 0 with jump_state=FALL, then 1, 2, …, 6, holding at 6; grounded=1 → GROUND, 0.
- Full hold:
  - Stimulus: press and hold the key.
  - Required: vel -10 for 9 frames (launch + 8 held), then -9, -8, …; jump_state=FALL on reaching 0.
- Double jump:
  - Stimulus: press, release, re-press at vel=-4.
  - Required: vel returns to -10, air_jumps_used=1. A third press is ignored and gravity continues. Landing clears air_jumps_used to 0.
- Head bump:
  - Stimulus: head_bump=1 at vel=-7.
  - Required: vel=0, jump_state=FALL, then 1, 2, ….
- Ledge and held key:
  - Stimulus: grounded→0 in GROUND with no key.
  - Required: FALL, vel=1.
  - Stimulus: land with the key still held.
  - Required: GROUND with no relaunch until release and re-press.
- Gating / reset:
  - Stimulus: frame_en=0 for 5 Clks mid-RISE.
  - Required: all outputs frozen.
  - Stimulus: Reset=1 mid-RISE with frame_en=0.
  - Required: next Clk gives GROUND, vel=0, air_jumps_used=0.
